// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD complementer.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} bcd_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Hex-capable 7-segment table, {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit_comp.sv
// One-digit complement step: r = 9 - d + carry_in, wrapping 10 to 0 with carry.
module bcd_digit_comp
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       carry_in,
  output logic [3:0] res,
  output logic       carry_out,
  output logic       bad
);

  logic [4:0] r;

  // Invalid digits force a zero result and kill the ripple carry
  always_comb begin
    r         = {1'b0, BCD_MAX} - {1'b0, d} + {4'b0, carry_in};
    bad       = (d > BCD_MAX);
    res       = 4'd0;
    carry_out = 1'b0;
    if (!bad) begin
      if (r == 5'd10) begin
        res       = 4'd0;
        carry_out = 1'b1;
      end else begin
        res       = r[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_comp_seq.sv
// Sequential multi-digit 9's/10's complementer, one digit per clock LSD first,
// with per-digit 7-segment output of the last completed result.
module bcd_comp_seq
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 8,
  localparam int IDX_W  = $clog2(DIGITS + 1)
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  cout,
  output logic                  err,
  output logic [7*DIGITS-1:0]   seg
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  bcd_state_t                  state_q, state_d;
  logic [DIGITS-1:0][3:0]      opnd_q, opnd_d;
  logic [DIGITS-1:0][3:0]      res_q, res_d;
  logic [DIGITS-1:0][3:0]      dout_q, dout_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        carry_q, carry_d;
  logic                        cout_q, cout_d;
  logic                        err_q, err_d;
  logic                        done_q, done_d;

  logic [3:0]                  dig_cur;
  logic [3:0]                  dc_res;
  logic                        dc_cout;
  logic                        dc_bad;

  // Select the operand digit addressed by the current index
  always_comb begin
    dig_cur = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == IDX_W'(i)) dig_cur = opnd_q[i];
  end

  bcd_digit_comp u_digit (
    .d         (dig_cur),
    .carry_in  (carry_q),
    .res       (dc_res),
    .carry_out (dc_cout),
    .bad       (dc_bad)
  );

  // FSM and datapath next-state
  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d  = din;
          carry_d = mode;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        carry_d = dc_cout;
        if (dc_bad) err_d = 1'b1;
        for (int i = 0; i < DIGITS; i++)
          if (idx_q == IDX_W'(i)) res_d[i] = dc_res;
        if (idx_q == LAST) state_d = DONE;
        else               idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        // Publish the result; done is registered so it coincides with dout
        dout_d  = res_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, async active-low reset aborts any operation
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = done_q;
  assign dout = dout_q;
  assign cout = cout_q;
  assign err  = err_q;

  // Leading-zero mask, scanned from the MSD down; digit 0 is always shown
  logic [DIGITS-1:0] show;
  logic              seen;
  always_comb begin
    seen = 1'b0;
    show = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen    = seen | (dout_q[k] != 4'd0);
      show[k] = seen | ~blank_lz | (k == 0);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign seg[7*k +: 7] = show[k] ? seg7(dout_q[k]) : 7'b0;
  end

endmodule

// File: tb/tb_bcd_comp_seq.sv
// Directed bench for bcd_comp_seq with DIGITS=4.
module tb_bcd_comp_seq;

  localparam int DIGITS = 4;

  logic                hz100;
  logic                reset;
  logic                start;
  logic                mode;
  logic                blank_lz;
  logic [4*DIGITS-1:0] din;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] dout;
  logic                cout;
  logic                err;
  logic [7*DIGITS-1:0] seg;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_comp_seq #(.DIGITS(DIGITS)) dut (
    .hz100    (hz100),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .blank_lz (blank_lz),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .cout     (cout),
    .err      (err),
    .seg      (seg)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse and wait (bounded) for done; lat = edges from start edge to done
  task automatic run_op(input logic [15:0] d, input logic m, output int lat);
    @(negedge hz100);
    din   = d;
    mode  = m;
    start = 1'b1;
    @(posedge hz100);
    #1 start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(posedge hz100);
      #1;
      if (done) lat = k;
    end
  endtask

  int lat;
  int ndone;
  int first;
  logic [15:0] cap;

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    din      = '0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dout", {16'b0, dout}, 32'h0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    chk("rst_err",  {31'b0, err},  32'd0);
    chk("rst_seg",  {4'b0, seg},   {4'b0, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
    @(negedge hz100);
    @(negedge hz100);
    reset = 1'b1;

    // 9's complement of 1234
    run_op(16'h1234, 1'b0, lat);
    chk("lat_1234_m0",  32'(lat), 32'd5);
    chk("dout_1234_m0", {16'b0, dout}, 32'h8765);
    chk("cout_1234_m0", {31'b0, cout}, 32'd0);
    chk("err_1234_m0",  {31'b0, err},  32'd0);
    chk("seg_8765",     {4'b0, seg},   {4'b0, 7'h7F, 7'h07, 7'h7D, 7'h6D});
    @(posedge hz100); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("dout_held",      {16'b0, dout}, 32'h8765);

    // 10's complement
    run_op(16'h1234, 1'b1, lat);
    chk("lat_1234_m1",  32'(lat), 32'd5);
    chk("dout_1234_m1", {16'b0, dout}, 32'h8766);
    chk("cout_1234_m1", {31'b0, cout}, 32'd0);

    run_op(16'h0000, 1'b1, lat);
    chk("lat_0000_m1",  32'(lat), 32'd5);
    chk("dout_0000_m1", {16'b0, dout}, 32'h0000);
    chk("cout_0000_m1", {31'b0, cout}, 32'd1);
    blank_lz = 1'b1;
    #1;
    chk("seg_zero_blank", {4'b0, seg}, {4'b0, 21'b0, 7'h3F});
    blank_lz = 1'b0;

    // Invalid digit
    run_op(16'h12A4, 1'b0, lat);
    chk("lat_12a4",  32'(lat), 32'd5);
    chk("dout_12a4", {16'b0, dout}, 32'h8705);
    chk("err_12a4",  {31'b0, err},  32'd1);
    chk("cout_12a4", {31'b0, cout}, 32'd0);
    @(posedge hz100); #1;
    chk("err_sticky", {31'b0, err}, 32'd1);

    run_op(16'h0009, 1'b0, lat);
    chk("lat_0009",  32'(lat), 32'd5);
    chk("dout_0009", {16'b0, dout}, 32'h9990);
    chk("err_clear", {31'b0, err},  32'd0);

    // Start re-pulsed during CALC with a different operand
    @(negedge hz100);
    din   = 16'h1234;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge hz100);
    ndone = 0;
    first = -1;
    cap   = '0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (k <= 3) begin
        start = 1'b1;
        din   = 16'h5555;
        mode  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge hz100);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = k;
          cap   = dout;
        end
      end
    end
    chk("repulse_ndone", 32'(ndone), 32'd1);
    chk("repulse_lat",   32'(first), 32'd5);
    chk("repulse_dout",  {16'b0, cap}, 32'h8765);

    // Reset two cycles into CALC
    @(negedge hz100);
    din   = 16'h0009;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge hz100);
    #1 start = 1'b0;
    @(posedge hz100);
    @(posedge hz100);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_dout", {16'b0, dout}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge hz100);
    @(negedge hz100);
    reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge hz100); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    run_op(16'h0420, 1'b0, lat);
    chk("lat_after_abort",  32'(lat), 32'd5);
    chk("dout_after_abort", {16'b0, dout}, 32'h9579);

    // Leading-zero blanking on 0008
    run_op(16'h9991, 1'b0, lat);
    chk("lat_9991",  32'(lat), 32'd5);
    chk("dout_9991", {16'b0, dout}, 32'h0008);
    blank_lz = 1'b1;
    #1;
    chk("seg_blank_on",  {4'b0, seg}, {4'b0, 21'b0, 7'h7F});
    blank_lz = 1'b0;
    #1;
    chk("seg_blank_off", {4'b0, seg}, {4'b0, 7'h3F, 7'h3F, 7'h3F, 7'h7F});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
